// File: rtl/multi_cycle_signed_adder_pkg.sv
// Shared definitions for the nibble-serial signed adder: slice width and FSM encoding.
package multi_cycle_signed_adder_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/four_bit_signed_adder.sv
// Four-bit ripple-carry slice; the serial adder reuses it once per nibble.
module four_bit_signed_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] out,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[4];

    for (genvar i = 0; i < 4; i++) begin : g_fa
        full_adder_gatelevel_module u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (out[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/full_adder_gatelevel_module.sv
// One-bit full adder built from gate primitives.
module full_adder_gatelevel_module (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic axb;
    logic gen;
    logic prop;

    xor u_x1 (axb, a, b);
    xor u_x2 (sum, axb, cin);
    and u_a1 (gen, a, b);
    and u_a2 (prop, axb, cin);
    or  u_o1 (cout, gen, prop);

endmodule

// File: rtl/multi_cycle_signed_adder.sv
// Sequential signed adder: one 4-bit slice processes the operands LSB nibble first,
// with a start/busy/done handshake around the operation.
module multi_cycle_signed_adder
    import multi_cycle_signed_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NSL   = WIDTH / SLICE_W;
    localparam int unsigned IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

    state_t                          state;
    logic [IDX_W-1:0]                idx;
    logic                            carry;
    logic [NSL-1:0][SLICE_W-1:0]     a_r;
    logic [NSL-1:0][SLICE_W-1:0]     b_r;
    logic [NSL-1:0][SLICE_W-1:0]     sum_r;
    logic [SLICE_W-1:0]              slice_sum;
    logic                            slice_cout;

    // Nibble mux into the shared slice.
    four_bit_signed_adder u_slice (
        .a    (a_r[idx]),
        .b    (b_r[idx]),
        .cin  (carry),
        .out  (slice_sum),
        .cout (slice_cout)
    );

    assign sum = sum_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            sum_r    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r[idx] <= slice_sum;
                    carry      <= slice_cout;
                    idx        <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        // Final slice: its MSB is the sign of the completed sum.
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cout     <= slice_cout;
                        overflow <= (a_r[NSL-1][SLICE_W-1] == b_r[NSL-1][SLICE_W-1]) &&
                                    (slice_sum[SLICE_W-1] != a_r[NSL-1][SLICE_W-1]);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
